mealy_share_ctrl: RTL and testbench



---
 rtl/mealy_share_ctrl.sv | 83 ++++++++
 tb/tb_mealy_share_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mealy_share_ctrl.sv
// mealy_share_ctrl: round-robin arbiter that time-shares one serial Mealy machine between two requesters
module mealy_share_ctrl #(
    parameter int LEN = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0,
    input  logic [LEN-1:0] pat0,
    input  logic           req1,
    input  logic [LEN-1:0] pat1,
    output logic           gnt0,
    output logic           gnt1,
    output logic           busy,
    output logic           done0,
    output logic           done1,
    output logic [LEN-1:0] resp,
    output logic [2:0]     resp_state,
    output logic           fsm_rst_n,
    output logic           fsm_in,
    input  logic           fsm_out,
    input  logic [2:0]     fsm_state
);
    localparam int CW = $clog2(LEN + 1);
    typedef enum logic [1:0] {IDLE, CLR, RUN, FIN} state_t;
    state_t         state;
    logic [LEN-1:0] sh;
    logic [LEN-1:0] acc;
    logic [CW-1:0]  cnt;
    logic           last;
    logic           pick;
    // on a tie the requester not served last wins
    assign pick      = (req0 && req1) ? !last : req1;
    assign busy      = state != IDLE;
    assign fsm_in    = (state == RUN) && sh[LEN-1];
    assign fsm_rst_n = !(rst || state == CLR);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sh         <= '0;
            acc        <= '0;
            cnt        <= '0;
            last       <= 1'b1;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            resp       <= '0;
            resp_state <= '0;
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state)
                IDLE: if (req0 || req1) begin
                    sh    <= pick ? pat1 : pat0;
                    gnt0  <= !pick;
                    gnt1  <= pick;
                    state <= CLR;
                end
                CLR: begin
                    cnt   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    acc   <= {acc[LEN-2:0], fsm_out};
                    sh    <= {sh[LEN-2:0], 1'b0};
                    cnt   <= cnt + 1'b1;
                    state <= (cnt == CW'(LEN - 1)) ? FIN : RUN;
                end
                FIN: begin
                    resp       <= acc;
                    resp_state <= fsm_state;
                    done0      <= gnt0;
                    done1      <= gnt1;
                    last       <= gnt1;
                    gnt0       <= 1'b0;
                    gnt1       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mealy_share_ctrl.sv
// tb_mealy_share_ctrl: scoreboard bench with a stand-in 6-state Mealy machine and a transaction-level reference model
module tb_mealy_share_ctrl;
    localparam int LEN = 8;
    logic           clk = 0, rst = 1, req0 = 0, req1 = 0;
    logic [LEN-1:0] pat0 = '0, pat1 = '0;
    logic           gnt0, gnt1, busy, done0, done1, fsm_rst_n, fsm_in, fsm_out;
    logic [LEN-1:0] resp;
    logic [2:0]     resp_state, fsm_state;

    always #5 clk = ~clk;

    mealy_share_ctrl #(.LEN(LEN)) dut (
        .clk(clk), .rst(rst), .req0(req0), .pat0(pat0), .req1(req1), .pat1(pat1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done0(done0), .done1(done1),
        .resp(resp), .resp_state(resp_state), .fsm_rst_n(fsm_rst_n), .fsm_in(fsm_in),
        .fsm_out(fsm_out), .fsm_state(fsm_state)
    );

    // machine transition table: returns {out, next}
    function automatic logic [3:0] mealy(input logic [2:0] s, input logic b);
        case ({s, b})
            4'b000_0: return {1'b0, 3'd0};
            4'b000_1: return {1'b1, 3'd1};
            4'b001_0: return {1'b1, 3'd3};
            4'b001_1: return {1'b0, 3'd2};
            4'b010_0: return {1'b0, 3'd1};
            4'b010_1: return {1'b1, 3'd4};
            4'b011_0: return {1'b0, 3'd0};
            4'b011_1: return {1'b0, 3'd5};
            4'b100_0: return {1'b1, 3'd5};
            4'b100_1: return {1'b1, 3'd4};
            4'b101_0: return {1'b1, 3'd2};
            4'b101_1: return {1'b1, 3'd4};
            default:  return {1'b0, 3'd0};
        endcase
    endfunction

    logic [2:0] m_st;
    logic [3:0] m_o;
    assign m_o       = mealy(m_st, fsm_in);
    assign fsm_out   = m_o[3];
    assign fsm_state = m_st;
    always @(posedge clk) m_st <= !fsm_rst_n ? 3'd0 : m_o[2:0];

    function automatic logic [LEN+2:0] golden(input logic [LEN-1:0] p);
        logic [2:0]     s = 3'd0;
        logic [LEN-1:0] r = '0;
        logic [3:0]     o;
        for (int i = LEN - 1; i >= 0; i--) begin
            o = mealy(s, p[i]);
            r = {r[LEN-2:0], o[3]};
            s = o[2:0];
        end
        return {r, s};
    endfunction

    typedef struct {bit idx; logic [LEN-1:0] r; logic [2:0] s;} exp_t;
    exp_t q[$];
    exp_t m_exp;
    int checks = 0, passed = 0;
    int m_busy = 0;
    bit m_w = 0, m_last = 1, m_done = 0;
    logic [LEN-1:0] m_pat = '0, m_resp = '0;
    logic [2:0] m_rstate = '0;
    int g0_cnt = 0, rn_cnt = 0, d0_cnt = 0, d1_cnt = 0;
    bit order[$];
    bit pg0 = 0, pg1 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // transaction-level model: a grant occupies LEN+2 busy cycles, then done
    initial forever begin
        logic [LEN+2:0] g;
        @(posedge clk or posedge rst);
        m_done = 0;
        if (rst) begin
            m_busy = 0; m_last = 1; m_resp = '0; m_rstate = '0;
            q.delete();
        end else if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
                m_done = 1; m_last = m_w; m_resp = m_exp.r; m_rstate = m_exp.s;
            end
        end else if (req0 || req1) begin
            m_w = (req0 && req1) ? !m_last : req1;
            m_pat = m_w ? pat1 : pat0;
            g = golden(m_pat);
            m_exp.idx = m_w; m_exp.r = g[LEN+2:3]; m_exp.s = g[2:0];
            q.push_back(m_exp);
            m_busy = LEN + 2;
        end
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        chk("gnt0", gnt0, m_busy > 0 && !m_w);
        chk("gnt1", gnt1, m_busy > 0 && m_w);
        chk("busy", busy, m_busy > 0);
        chk("fsm_rst_n", fsm_rst_n, !(rst || m_busy == LEN + 2));
        chk("fsm_in", fsm_in, (m_busy >= 2 && m_busy <= LEN + 1) ? m_pat[m_busy-2] : 1'b0);
        chk("resp_hold", resp, m_resp);
        chk("resp_state_hold", resp_state, m_rstate);
        chk("done_timing", {done1, done0}, m_done ? (m_w ? 2'b10 : 2'b01) : 2'b00);
        if (done0 || done1) begin
            if (q.size() == 0) chk("done_unexpected", done0 | done1, 0);
            else begin
                e = q.pop_front();
                chk("sb_idx", {done1, done0}, e.idx ? 2'b10 : 2'b01);
                chk("sb_resp", resp, e.r);
                chk("sb_state", resp_state, e.s);
            end
        end
        if (gnt0) g0_cnt++;
        if (!fsm_rst_n && !rst) rn_cnt++;
        if (done0) d0_cnt++;
        if (done1) d1_cnt++;
        if ((gnt0 && !pg0) || (gnt1 && !pg1)) order.push_back(gnt1);
        pg0 = gnt0; pg1 = gnt1;
    end

    task automatic run_one(input bit idx, input logic [LEN-1:0] p,
                           input logic [LEN-1:0] er, input logic [2:0] es);
        int d = idx ? d1_cnt : d0_cnt;
        int g = g0_cnt;
        int rn = rn_cnt;
        @(negedge clk); #1;
        if (idx) begin req1 = 1; pat1 = p; end else begin req0 = 1; pat0 = p; end
        @(negedge clk); #1;
        req0 = 0; req1 = 0;
        repeat (LEN + 3) @(negedge clk);
        #1;
        chk("dir_resp", resp, er);
        chk("dir_state", resp_state, es);
        chk("dir_done", (idx ? d1_cnt : d0_cnt) - d, 1);
        chk("dir_gnt0_cycles", g0_cnt - g, idx ? 0 : LEN + 2);
        chk("dir_clr_cycles", rn_cnt - rn, 1);
    endtask

    task automatic pulse_rst();
        @(negedge clk); #1; rst = 1;
        @(negedge clk); #1; rst = 0;
    endtask

    initial begin
        logic [LEN+2:0] g;
        logic [LEN-1:0] p;
        int d;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_gnt", {gnt1, gnt0}, 0);
        chk("rst_done", {done1, done0}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_resp", resp, 0);
        chk("rst_fsm_rst_n", fsm_rst_n, 0);
        rst = 0;
        run_one(0, 8'hB0, 8'hDD, 3'b011);
        run_one(1, 8'hFF, 8'hBF, 3'b100);
        run_one(0, 8'h00, 8'h00, 3'b000);
        // both held high from reset: strict alternation, no gap beyond done
        pulse_rst();
        order.delete();
        req0 = 1; req1 = 1; pat0 = LEN'($urandom); pat1 = LEN'($urandom);
        repeat (4 * (LEN + 3)) @(negedge clk);
        #1; req0 = 0; req1 = 0;
        repeat (LEN + 4) @(negedge clk);
        chk("rr_count", order.size(), 4);
        for (int i = 0; i < order.size() && i < 4; i++) chk("rr_order", order[i], i % 2);
        // pattern change and req drop during RUN
        p = LEN'($urandom); g = golden(p); d = d0_cnt;
        @(negedge clk); #1; req0 = 1; pat0 = p;
        @(negedge clk); #1; req0 = 0;
        repeat (3) @(negedge clk);
        #1; pat0 = ~p;
        repeat (LEN + 2) @(negedge clk);
        #1;
        chk("latched_resp", resp, g[LEN+2:3]);
        chk("latched_state", resp_state, g[2:0]);
        chk("latched_done", d0_cnt - d, 1);
        // reset in the middle of RUN aborts
        d = d0_cnt;
        @(negedge clk); #1; req0 = 1; pat0 = LEN'($urandom);
        @(negedge clk); #1; req0 = 0;
        repeat (3) @(negedge clk);
        #1; rst = 1; #1;
        chk("mid_rst_gnt", {gnt1, gnt0}, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_resp", resp, 0);
        chk("mid_rst_fsm_rst_n", fsm_rst_n, 0);
        chk("mid_rst_fsm_in", fsm_in, 0);
        @(negedge clk); #1; rst = 0;
        repeat (LEN + 4) @(negedge clk);
        chk("abort_no_done", d0_cnt - d, 0);
        p = LEN'($urandom); g = golden(p);
        run_one(0, p, g[LEN+2:3], g[2:0]);
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #1;
            req0 = ($urandom_range(0, 3) != 0);
            req1 = ($urandom_range(0, 2) == 0);
            pat0 = LEN'($urandom); pat1 = LEN'($urandom);
        end
        req0 = 0; req1 = 0;
        repeat (LEN + 5) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish in time");
        $fatal(1);
    end
endmodule
